// File: rtl/pipeline_control_unit.sv
// Pipeline stall/flush/halt sequencer with a sticky stall watchdog.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
//
// state    | meaning
// ST_RUN   | normal issue; stalls, flushes and halts are taken from here
// ST_FLUSH | extra squash cycles after a taken branch/jump
// ST_HALT  | pipeline frozen until resume
module pipeline_control_unit #(
    parameter int unsigned FLUSH_LEN = 1,
    parameter int unsigned MAX_STALL = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        flush_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic        stall_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;

    localparam logic [1:0] FLUSH_LEN_V = 2'(FLUSH_LEN);
    localparam logic [7:0] MAX_STALL_V = 8'(MAX_STALL);

    state_e     state_q, state_d;
    logic [1:0] squash_q, squash_d;
    logic [7:0] stall_run_q, stall_run_d;
    logic       timeout_q, timeout_d;
    logic       stall_apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            squash_q    <= '0;
            stall_run_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    squash_d = FLUSH_LEN_V;
                    state_d  = (FLUSH_LEN_V != 2'd0) ? ST_FLUSH : ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    squash_d = FLUSH_LEN_V;
                end else if (squash_q <= 2'd1) begin
                    squash_d = 2'd0;
                    state_d  = ST_RUN;
                end else begin
                    squash_d = squash_q - 2'd1;
                end
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: begin
                state_d  = ST_RUN;
                squash_d = 2'd0;
            end
        endcase
    end

    // Only a stall that actually freezes the front end counts toward the watchdog.
    assign stall_apply = (state_q == ST_RUN) && stall_req && !flush_req && !halt_req;

    always_comb begin
        stall_run_d = '0;
        if (stall_apply)
            stall_run_d = (stall_run_q == 8'hFF) ? stall_run_q : stall_run_q + 8'd1;
        timeout_d = timeout_q | (stall_run_d >= MAX_STALL_V);
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (halt_req || stall_req) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_FLUSH: ifid_flush = 1'b1;
            ST_HALT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted        = (state_q == ST_HALT);
    assign stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cyc_q, stall_cyc_d;
    logic [15:0] flush_cyc_q, flush_cyc_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_cyc_d = flush_cyc_q;
        if (stall_apply && stall_cyc_q != 16'hFFFF) stall_cyc_d = stall_cyc_q + 16'd1;
        if (ifid_flush && flush_cyc_q != 16'hFFFF) flush_cyc_d = flush_cyc_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cyc_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cyc_q <= flush_cyc_d;
        end
    end

    assign stall_cycles = stall_cyc_q;
    assign flush_cycles = flush_cyc_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the control rules.
module tb_pipeline_control_unit;

    localparam int FLUSH_LEN = 1;
    localparam int MAX_STALL = 7;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_req = 1'b0, flush_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, halted, stall_timeout;
    logic [15:0] stall_cycles, flush_cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipeline_control_unit #(.FLUSH_LEN(FLUSH_LEN), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst),
        .stall_req(stall_req), .flush_req(flush_req), .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state: remaining squash cycles, halt flag, stall run length, perf totals.
    int m_squash, m_run, m_sc, m_fc;
    bit m_halt, m_to;

    always @(negedge clk) begin : model_cmp
        bit e_pc, e_en, e_fl, e_bub, applied;
        if (rst) begin
            m_squash = 0; m_halt = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
        end
        e_pc = 1; e_en = 1; e_fl = 0; e_bub = 0; applied = 0;
        if (m_halt) begin
            e_pc = 0; e_en = 0; e_bub = 1;
        end else if (m_squash > 0) begin
            e_fl = 1;
        end else if (flush_req) begin
            e_fl = 1; e_bub = 1;
        end else if (halt_req) begin
            e_pc = 0; e_en = 0; e_bub = 1;
        end else if (stall_req) begin
            e_pc = 0; e_en = 0; e_bub = 1; applied = 1;
        end
        chk("m_pc_en", pc_en, e_pc);
        chk("m_ifid_en", ifid_en, e_en);
        chk("m_ifid_flush", ifid_flush, e_fl);
        chk("m_idex_bubble", idex_bubble, e_bub);
        chk("m_halted", halted, m_halt);
        chk("m_stall_timeout", stall_timeout, m_to);
        chk("m_stall_cycles", stall_cycles, PERF ? m_sc : 0);
        chk("m_flush_cycles", flush_cycles, PERF ? m_fc : 0);
        if (!rst) begin
            if (m_halt) begin
                if (resume) m_halt = 0;
            end else if (m_squash > 0) begin
                m_squash = flush_req ? FLUSH_LEN : m_squash - 1;
            end else if (flush_req) begin
                m_squash = FLUSH_LEN;
            end else if (halt_req) begin
                m_halt = 1;
            end
            m_run = applied ? ((m_run < 255) ? m_run + 1 : 255) : 0;
            if (m_run >= MAX_STALL) m_to = 1;
            if (applied && m_sc < 65535) m_sc++;
            if (e_fl && m_fc < 65535) m_fc++;
        end
    end

    task automatic set_in(input bit s, input bit f, input bit h, input bit r);
        stall_req = s; flush_req = f; halt_req = h; resume = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_idex_bubble", idex_bubble, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", stall_timeout, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        @(negedge clk); #2 rst = 1'b0;
        tick();

        // single-cycle stall
        set_in(1, 0, 0, 0);
        chk("stall_pc_en", pc_en, 0);
        chk("stall_ifid_en", ifid_en, 0);
        chk("stall_bubble", idex_bubble, 1);
        tick();
        set_in(0, 0, 0, 0);
        chk("stall_next_pc_en", pc_en, 1);
        chk("stall_cycles_1", stall_cycles, PERF ? 1 : 0);
        tick();

        // flush with simultaneous stall
        set_in(1, 1, 0, 0);
        chk("fl0_ifid_flush", ifid_flush, 1);
        chk("fl0_bubble", idex_bubble, 1);
        chk("fl0_pc_en", pc_en, 1);
        tick();
        set_in(0, 0, 0, 0);
        chk("fl1_ifid_flush", ifid_flush, 1);
        chk("fl1_bubble", idex_bubble, 0);
        tick();
        chk("fl2_ifid_flush", ifid_flush, 0);
        chk("fl2_pc_en", pc_en, 1);
        chk("flush_cycles_2", flush_cycles, PERF ? 2 : 0);
        tick();

        // halt, ignore traffic, resume
        set_in(0, 0, 1, 0);
        chk("halt_req_pc_en", pc_en, 0);
        chk("halt_req_halted", halted, 0);
        tick();
        set_in(0, 0, 0, 0);
        chk("halt_halted", halted, 1);
        for (int i = 0; i < 10; i++) begin
            set_in(i % 2 == 0, i % 3 == 0, 0, 0);
            chk("halt_hold_pc_en", pc_en, 0);
            chk("halt_hold_flush", ifid_flush, 0);
            tick();
        end
        set_in(0, 0, 0, 1);
        chk("resume_cycle_halted", halted, 1);
        tick();
        set_in(0, 0, 0, 0);
        chk("resumed_halted", halted, 0);
        chk("resumed_pc_en", pc_en, 1);
        set_in(0, 0, 0, 1);
        chk("resume_in_run_pc_en", pc_en, 1);
        tick();
        set_in(0, 0, 0, 0);
        chk("resume_in_run_halted", halted, 0);

        // watchdog: 6 stalls stay clear, 7 stalls set the sticky flag
        for (int i = 0; i < 6; i++) begin set_in(1, 0, 0, 0); tick(); end
        set_in(0, 0, 0, 0);
        chk("timeout_after_6", stall_timeout, 0);
        tick();
        for (int i = 0; i < 7; i++) begin set_in(1, 0, 0, 0); tick(); end
        set_in(0, 0, 0, 0);
        chk("timeout_after_7", stall_timeout, 1);
        tick(); tick();
        chk("timeout_sticky", stall_timeout, 1);

        // priority corners
        set_in(1, 0, 1, 0);
        chk("halt_over_stall_pc", pc_en, 0);
        tick();
        set_in(0, 0, 0, 0);
        chk("halt_over_stall_halted", halted, 1);
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 1, 1, 0);
        chk("flush_over_halt_fl", ifid_flush, 1);
        tick();
        set_in(0, 1, 0, 0);
        chk("flush_over_halt_halted", halted, 0);
        tick();
        set_in(0, 0, 0, 0);
        chk("flush_reload_fl", ifid_flush, 1);
        tick();
        chk("flush_reload_done", ifid_flush, 0);

        // async reset mid-FLUSH
        set_in(0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        chk("pre_rst_in_flush", ifid_flush, 1);
        rst = 1'b1;
        #1;
        chk("rstf_ifid_flush", ifid_flush, 0);
        chk("rstf_pc_en", pc_en, 1);
        chk("rstf_timeout", stall_timeout, 0);
        chk("rstf_flush_cycles", flush_cycles, 0);
        @(negedge clk); #2 rst = 1'b0;
        tick();
        chk("post_rstf_flush", ifid_flush, 0);

        // async reset mid-HALT
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        chk("pre_rst_halted", halted, 1);
        rst = 1'b1;
        #1;
        chk("rsth_halted", halted, 0);
        chk("rsth_pc_en", pc_en, 1);
        chk("rsth_bubble", idex_bubble, 0);
        @(negedge clk); #2 rst = 1'b0;
        tick();
        chk("post_rsth_halted", halted, 0);

        // mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            set_in(i % 3 == 0, (i % 7 == 2) || (i == 3), i == 20, i == 26);
            tick();
        end
        set_in(0, 0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter FLUSH_LEN, default 1, number of extra squash cycles after the flush request cycle (range 0..3).
REQ-002 Parameter MAX_STALL, default 7, consecutive stall cycles before stall_timeout sets (range 1..255).
REQ-003 Single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 stall_req  input  1  load-use stall request from the hazard/forwarding unit, combinational, same cycle.
REQ-007 flush_req  input  1  taken-branch/jump resolved in EX, one-cycle pulse.
REQ-008 halt_req  input  1  HLT instruction decoded in EX, one-cycle pulse.
REQ-009 resume  input  1  external resume/interrupt pulse, leaves HALT.
REQ-010 pc_en  output  1  PC register load enable.
REQ-011 ifid_en  output  1  IF/ID pipeline register enable.
REQ-012 ifid_flush  output  1  clear IF/ID to NOP.
REQ-013 idex_bubble  output  1  load NOP (all write/mem enables 0) into ID/EX.
REQ-014 halted  output  1  high while in HALT.
REQ-015 stall_timeout  output  1  sticky watchdog flag.
REQ-016 stall_cycles  output  16  performance counter, stall cycles.
REQ-017 flush_cycles  output  16  performance counter, squash cycles.

Function
REQ-018 States RUN, FLUSH, HALT held in a registered state; outputs are combinational from state and inputs (zero-cycle reaction to stall_req).
REQ-019 Request priority in RUN, same cycle: flush_req > halt_req > stall_req.
REQ-020 RUN, no request: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0; stays RUN.
REQ-021 RUN, stall_req only: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0; stays RUN; repeats every cycle stall_req is high.
REQ-022 RUN, flush_req: pc_en=1, ifid_flush=1, idex_bubble=1, stall_req ignored; next state FLUSH if FLUSH_LEN>0, else RUN; squash counter loads FLUSH_LEN.
REQ-023 FLUSH: pc_en=1, ifid_flush=1, idex_bubble=0; counter decrements each cycle; at count 1 next state RUN; flush_req in FLUSH reloads counter to FLUSH_LEN; stall_req and halt_req ignored in FLUSH.
REQ-024 RUN, halt_req (no flush_req): pc_en=0, ifid_en=0, idex_bubble=1 in request cycle; next state HALT.
REQ-025 HALT: pc_en=0, ifid_en=0, idex_bubble=1, halted=1; resume -> RUN next cycle; all other inputs ignored; resume outside HALT ignored.
REQ-026 Consecutive-stall counter (8-bit, saturating) increments on each RUN cycle with stall_req asserted and applied, clears on any other cycle; stall_timeout sets when it reaches MAX_STALL, cleared only by reset.

Reset
REQ-027 rst asserted, any cycle: state=RUN, squash and stall counters=0, stall_timeout=0, stall_cycles=0, flush_cycles=0, halted=0.
REQ-028 During reset outputs read pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0 (RUN, no requests); reset mid-FLUSH or mid-HALT aborts to RUN with no residual squash.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: stall_cycles increments on each applied stall cycle (REQ-021), flush_cycles on each cycle with ifid_flush=1; both saturate at 16'hFFFF.
REQ-030 Macro PIPE_PERF_CNT_EN undefined: both counters absent, stall_cycles and flush_cycles tied to 0; all other behaviour identical.

Verification
REQ-031 RUN, stall_req high 1 cycle -> same cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle pc_en=1; stall_cycles=1 (macro on).
REQ-032 FLUSH_LEN=1, flush_req and stall_req together -> cycle0 ifid_flush=1, idex_bubble=1, pc_en=1; cycle1 ifid_flush=1, idex_bubble=0; cycle2 RUN; flush_cycles=2.
REQ-033 halt_req pulse -> halted=1 next cycle, pc_en=0 held 10 cycles with stall_req/flush_req toggling; resume -> RUN next cycle, halted=0.
REQ-034 MAX_STALL=7, stall_req held 7 cycles -> stall_timeout=1 after 7th cycle, stays 1 after stall_req drops; 6-cycle stall leaves it 0.
REQ-035 rst asserted asynchronously mid-FLUSH and mid-HALT -> immediate RUN outputs, counters 0, no ifid_flush after release.
REQ-036 Macro off: stall and flush sequences of REQ-031/032 -> stall_cycles=0, flush_cycles=0, control outputs unchanged.
